// File: rtl/image_feed_ctrl.sv
// rtl/image_feed_ctrl.sv - credit-metered pixel feed into the 4-line buffer block
// Define IMG_PAD_EN to append PAD_LINES zero lines at the bottom of each frame.
module image_feed_ctrl #(
  parameter int LINE_WIDTH = 512,
  parameter int NUM_LINES  = 4,
  parameter int IMG_HEIGHT = 512,
  parameter int PAD_LINES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] o_pixel_data,
  output logic       o_pixel_data_valid,
  input  logic       i_line_done,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_overflow,
  output logic [9:0] o_lines_done
);

  localparam logic [12:0] CREDIT_MAX  = 13'(LINE_WIDTH * NUM_LINES);
  localparam logic [12:0] CREDIT_STEP = 13'(LINE_WIDTH);
  localparam logic [18:0] SRC_LAST    = 19'(IMG_HEIGHT * LINE_WIDTH - 1);
`ifdef IMG_PAD_EN
  localparam logic [18:0] PAD_LAST    = 19'(PAD_LINES * LINE_WIDTH - 1);
  localparam logic [9:0]  EXPECTED    = 10'(IMG_HEIGHT + PAD_LINES - 2);
  typedef enum logic [2:0] {IDLE, FEED, PAD, DRAIN, DONE} state_t;
`else
  localparam logic [9:0]  EXPECTED    = 10'(IMG_HEIGHT - 2);
  typedef enum logic [2:0] {IDLE, FEED, DRAIN, DONE} state_t;
`endif

  state_t      state, state_nxt;
  logic [11:0] credit;
  logic [18:0] pix_cnt;
`ifdef IMG_PAD_EN
  logic [18:0] pad_cnt;
`endif
  logic [9:0]  lines_done;
  logic        overflow;
  logic        wr, wr_zero, line_cnt;
  logic [12:0] credit_sum;

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    wr        = 1'b0;
    wr_zero   = 1'b0;
    line_cnt  = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = FEED;
      FEED: begin
        s_ready  = (credit != 12'd0);
        wr       = s_valid && (credit != 12'd0);
        line_cnt = i_line_done;
        if (wr && pix_cnt == SRC_LAST) begin
`ifdef IMG_PAD_EN
          state_nxt = PAD;
`else
          state_nxt = DRAIN;
`endif
        end
      end
`ifdef IMG_PAD_EN
      PAD: begin
        wr       = (credit != 12'd0);
        wr_zero  = 1'b1;
        line_cnt = i_line_done;
        if (wr && pad_cnt == PAD_LAST) state_nxt = DRAIN;
      end
`endif
      DRAIN: begin
        line_cnt = i_line_done;
        if (lines_done == EXPECTED) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Never negative: a write only happens while credit is non-zero.
  assign credit_sum = {1'b0, credit} - {12'd0, wr} + (line_cnt ? CREDIT_STEP : 13'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      credit             <= 12'd0;
      pix_cnt            <= 19'd0;
`ifdef IMG_PAD_EN
      pad_cnt            <= 19'd0;
`endif
      lines_done         <= 10'd0;
      overflow           <= 1'b0;
      o_pixel_data       <= 8'h00;
      o_pixel_data_valid <= 1'b0;
    end else begin
      state              <= state_nxt;
      o_pixel_data_valid <= wr;
      if (wr) o_pixel_data <= wr_zero ? 8'h00 : s_data;
      if (state == IDLE) begin
        if (start) begin
          credit     <= CREDIT_MAX[11:0];
          pix_cnt    <= 19'd0;
`ifdef IMG_PAD_EN
          pad_cnt    <= 19'd0;
`endif
          lines_done <= 10'd0;
          overflow   <= 1'b0;
        end
      end else begin
        if (credit_sum > CREDIT_MAX) begin
          credit   <= CREDIT_MAX[11:0];
          overflow <= 1'b1;
        end else begin
          credit <= credit_sum[11:0];
        end
        if (wr && state == FEED) pix_cnt <= pix_cnt + 19'd1;
`ifdef IMG_PAD_EN
        if (wr && state == PAD) pad_cnt <= pad_cnt + 19'd1;
`endif
        if (line_cnt) lines_done <= lines_done + 10'd1;
      end
    end
  end

  assign o_busy       = (state != IDLE);
  assign o_frame_done = (state == DONE);
  assign o_overflow   = overflow;
  assign o_lines_done = lines_done;

endmodule
